reset_run_ctrl: RTL and testbench

//  Synthesizable reset sequencer and run watchdog for the cpu and its peripherals.
//  - Holds each core reset channel for a fixed number of cycles, then releases channels in staggered order.
//  - Counts run cycles and ends the run on a halt request or on a cycle timeout.
//  - Supports soft restart without asserting the global reset.
//  - Used by benches in place of ad-hoc reset/#delay sequencing.

---
 rtl/reset_run_ctrl.sv | 118 +++++++++++
 tb/tb_reset_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_run_ctrl.sv
// Reset sequencer and run watchdog: staggered per-channel reset release, then a
// counted run that ends on halt or timeout. Soft restart re-enters the hold phase.
module reset_run_ctrl #(
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned NUM_CH         = 1,
   parameter int unsigned STAGGER        = 0,
   parameter int unsigned TIMEOUT_CYCLES = 2000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_i,
   input  logic              restart_i,
   output logic [NUM_CH-1:0] core_rst,
   output logic              running,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam int unsigned LAST  = RST_CYCLES + (NUM_CH - 1) * STAGGER;
   localparam int unsigned SEQ_W = $clog2(LAST + 1);

   typedef enum logic [2:0] {StHold, StRelease, StRun, StDone, StTout} state_e;

   state_e            state_q, state_d;
   logic [SEQ_W-1:0]  seq_q, seq_d, seq_inc;
   logic [NUM_CH-1:0] core_rst_q, core_rst_d;
   logic              running_q, running_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sat;
   logic [63:0]       cnt_inc64;
   logic              tout_hit;

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      core_rst_d = core_rst_q;
      running_d  = running_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      cnt_d      = cnt_q;

      seq_inc   = seq_q + SEQ_W'(1);
      cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      // Timeout compares the unsaturated increment so a wide limit never aliases.
      cnt_inc64 = 64'(cnt_q) + 64'd1;
      tout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc64 == 64'(TIMEOUT_CYCLES));

      unique case (state_q)
         StHold, StRelease: begin
            seq_d = seq_inc;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
               if (seq_inc == SEQ_W'(RST_CYCLES + i * STAGGER)) core_rst_d[i] = 1'b0;
            end
            if (seq_inc == SEQ_W'(LAST)) begin
               state_d   = StRun;
               running_d = 1'b1;
               cnt_d     = '0;
            end else if (seq_inc >= SEQ_W'(RST_CYCLES)) begin
               state_d = StRelease;
            end
         end
         StRun: begin
            cnt_d = cnt_sat;
            if (halt_i) begin
               state_d   = StDone;
               running_d = 1'b0;
               done_d    = 1'b1;
            end else if (tout_hit) begin
               state_d   = StTout;
               running_d = 1'b0;
               timeout_d = 1'b1;
            end
         end
         default: ;
      endcase

      // Soft restart behaves as a synchronous reset; in hold it just extends the hold.
      if (restart_i) begin
         state_d    = StHold;
         seq_d      = '0;
         core_rst_d = '1;
         running_d  = 1'b0;
         done_d     = 1'b0;
         timeout_d  = 1'b0;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHold;
         seq_q      <= '0;
         core_rst_q <= '1;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         core_rst_q <= core_rst_d;
         running_q  <= running_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
      end
   end

   assign core_rst  = core_rst_q;
   assign running   = running_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_reset_run_ctrl.sv
// Directed bench for reset_run_ctrl across four parameter sets.
module tb_reset_run_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // a: defaults, b: TIMEOUT_CYCLES=8, c: 3 channels staggered, d: CNT_W=4 no timeout
   logic        rst_a = 1'b1, halt_a = 1'b0, restart_a = 1'b0;
   logic        core_rst_a, running_a, done_a, timeout_a;
   logic [31:0] cnt_a;
   logic        rst_b = 1'b1, halt_b = 1'b0, restart_b = 1'b0;
   logic        core_rst_b, running_b, done_b, timeout_b;
   logic [31:0] cnt_b;
   logic        rst_c = 1'b1, halt_c = 1'b0, restart_c = 1'b0;
   logic [2:0]  core_rst_c;
   logic        running_c, done_c, timeout_c;
   logic [31:0] cnt_c;
   logic        rst_d = 1'b1, halt_d = 1'b0, restart_d = 1'b0;
   logic        core_rst_d, running_d, done_d, timeout_d;
   logic [3:0]  cnt_d;

   reset_run_ctrl dut_a (
      .clk(clk), .rst(rst_a), .halt_i(halt_a), .restart_i(restart_a),
      .core_rst(core_rst_a), .running(running_a), .done(done_a), .timeout(timeout_a),
      .cycle_cnt(cnt_a)
   );

   reset_run_ctrl #(.TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .rst(rst_b), .halt_i(halt_b), .restart_i(restart_b),
      .core_rst(core_rst_b), .running(running_b), .done(done_b), .timeout(timeout_b),
      .cycle_cnt(cnt_b)
   );

   reset_run_ctrl #(.RST_CYCLES(2), .NUM_CH(3), .STAGGER(2)) dut_c (
      .clk(clk), .rst(rst_c), .halt_i(halt_c), .restart_i(restart_c),
      .core_rst(core_rst_c), .running(running_c), .done(done_c), .timeout(timeout_c),
      .cycle_cnt(cnt_c)
   );

   reset_run_ctrl #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_d (
      .clk(clk), .rst(rst_d), .halt_i(halt_d), .restart_i(restart_d),
      .core_rst(core_rst_d), .running(running_d), .done(done_d), .timeout(timeout_d),
      .cycle_cnt(cnt_d)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Vectors are {core_rst, running, done, timeout, cycle_cnt}.
   task automatic test_reset();
      rst_a = 1'b1;
      tick(2);
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b1000, 32'd0}) begin
         n_err++;
         $display("FAIL reset_state: got %b/%0d want 1000/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
      rst_a = 1'b0;
      tick();
      n_cmp++;
      if ({core_rst_a, running_a} !== 2'b10) begin
         n_err++;
         $display("FAIL release_edge1: got rst/run %b want 10", {core_rst_a, running_a});
      end
      tick();
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b0100, 32'd0}) begin
         n_err++;
         $display("FAIL release_edge2: got %b/%0d want 0100/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
   endtask

   task automatic test_halt();
      tick(9);
      n_cmp++;
      if (cnt_a !== 32'd9 || running_a !== 1'b1) begin
         n_err++;
         $display("FAIL run_count9: got cnt %0d run %b want 9 1", cnt_a, running_a);
      end
      halt_a = 1'b1;
      tick();
      halt_a = 1'b0;
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b0010, 32'd10}) begin
         n_err++;
         $display("FAIL halt_done: got %b/%0d want 0010/10",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
      tick(3);
      halt_a = 1'b1;
      tick();
      halt_a = 1'b0;
      tick();
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b0010, 32'd10}) begin
         n_err++;
         $display("FAIL halt_frozen: got %b/%0d want 0010/10",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
   endtask

   task automatic test_restart();
      restart_a = 1'b1;
      tick();
      restart_a = 1'b0;
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b1000, 32'd0}) begin
         n_err++;
         $display("FAIL restart_done: got %b/%0d want 1000/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
      tick();
      n_cmp++;
      if ({core_rst_a, running_a} !== 2'b10) begin
         n_err++;
         $display("FAIL rerun_edge1: got rst/run %b want 10", {core_rst_a, running_a});
      end
      tick();
      n_cmp++;
      if ({core_rst_a, running_a, cnt_a} !== {2'b01, 32'd0}) begin
         n_err++;
         $display("FAIL rerun_edge2: got rst/run %b cnt %0d want 01 0",
                  {core_rst_a, running_a}, cnt_a);
      end
      tick(3);
      // Restart in RUN together with halt: restart must win.
      restart_a = 1'b1;
      halt_a    = 1'b1;
      tick();
      restart_a = 1'b0;
      halt_a    = 1'b0;
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b1000, 32'd0}) begin
         n_err++;
         $display("FAIL restart_run: got %b/%0d want 1000/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
      tick(2);
      n_cmp++;
      if ({core_rst_a, running_a, cnt_a} !== {2'b01, 32'd0}) begin
         n_err++;
         $display("FAIL rerun2: got rst/run %b cnt %0d want 01 0",
                  {core_rst_a, running_a}, cnt_a);
      end
   endtask

   task automatic test_mid_run_rst();
      rst_a = 1'b1;
      tick();
      rst_a  = 1'b0;
      halt_a = 1'b1;
      tick(2);
      halt_a = 1'b0;
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b0100, 32'd0}) begin
         n_err++;
         $display("FAIL halt_in_hold: got %b/%0d want 0100/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
      tick(5);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      n_cmp++;
      if ({core_rst_a, running_a, done_a, timeout_a, cnt_a} !== {4'b1000, 32'd0}) begin
         n_err++;
         $display("FAIL rst_mid_run: got %b/%0d want 1000/0",
                  {core_rst_a, running_a, done_a, timeout_a}, cnt_a);
      end
   endtask

   task automatic test_timeout();
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      tick(2);
      tick(7);
      n_cmp++;
      if ({running_b, done_b, timeout_b, cnt_b} !== {3'b100, 32'd7}) begin
         n_err++;
         $display("FAIL tout_pre: got %b/%0d want 100/7", {running_b, done_b, timeout_b}, cnt_b);
      end
      tick();
      n_cmp++;
      if ({core_rst_b, running_b, done_b, timeout_b, cnt_b} !== {4'b0001, 32'd8}) begin
         n_err++;
         $display("FAIL tout_hit: got %b/%0d want 0001/8",
                  {core_rst_b, running_b, done_b, timeout_b}, cnt_b);
      end
      tick(3);
      n_cmp++;
      if ({running_b, done_b, timeout_b, cnt_b} !== {3'b001, 32'd8}) begin
         n_err++;
         $display("FAIL tout_hold: got %b/%0d want 001/8", {running_b, done_b, timeout_b}, cnt_b);
      end
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      tick(2 + 7);
      halt_b = 1'b1;
      tick();
      halt_b = 1'b0;
      n_cmp++;
      if ({running_b, done_b, timeout_b, cnt_b} !== {3'b010, 32'd8}) begin
         n_err++;
         $display("FAIL halt_vs_tout: got %b/%0d want 010/8", {running_b, done_b, timeout_b}, cnt_b);
      end
   endtask

   task automatic test_stagger();
      logic [2:0] exp_rst [6];
      logic       exp_run [6];
      exp_rst = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000};
      exp_run = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      rst_c = 1'b1;
      tick();
      rst_c = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         n_cmp++;
         if ({core_rst_c, running_c} !== {exp_rst[e], exp_run[e]}) begin
            n_err++;
            $display("FAIL stagger_edge%0d: got rst %b run %b want %b %b", e + 1,
                     core_rst_c, running_c, exp_rst[e], exp_run[e]);
         end
      end
   endtask

   task automatic test_saturate();
      rst_d = 1'b1;
      tick();
      rst_d = 1'b0;
      tick(2);
      tick(15);
      n_cmp++;
      if ({running_d, timeout_d, cnt_d} !== {2'b10, 4'd15}) begin
         n_err++;
         $display("FAIL sat_reach: got run/tout %b cnt %0d want 10 15", {running_d, timeout_d}, cnt_d);
      end
      tick(5);
      n_cmp++;
      if ({running_d, timeout_d, cnt_d} !== {2'b10, 4'd15}) begin
         n_err++;
         $display("FAIL sat_hold: got run/tout %b cnt %0d want 10 15", {running_d, timeout_d}, cnt_d);
      end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_restart();
      test_mid_run_rst();
      test_timeout();
      test_stagger();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
